// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and default constants.
// Redirect encoding plus reset/exception vectors.
package cpu_pkg;

  typedef enum logic [2:0] {
    REDIR_NONE,
    REDIR_BR,
    REDIR_JAL,
    REDIR_JR,
    REDIR_ERET,
    REDIR_EXC
  } redir_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/pc_gen_if.sv
// Decode/hazard side bundle for the PC generator.
// Master drives requests, slave returns fetch PC and RAS state.
interface pc_gen_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic [WIDTH-1:0] br_pc;
  logic             br_req;
  logic [15:0]      br_off;
  logic             jal_req;
  logic [25:0]      j_index;
  logic             jr_req;
  logic             jr_is_ra;
  logic [WIDTH-1:0] jr_target;
  logic             exc_req;
  logic             eret_req;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc4;
  logic [WIDTH-1:0] link_addr;
  logic             pend_vld;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic [CNT_W-1:0] ras_miss_cnt;

  modport master (
    output stall, br_pc, br_req, br_off,
    output jal_req, j_index, jr_req,
    output jr_is_ra, jr_target,
    output exc_req, eret_req, epc,
    input  pc, pc4, link_addr, pend_vld,
    input  ras_top, ras_empty, ras_miss_cnt
  );

  modport slave (
    input  stall, br_pc, br_req, br_off,
    input  jal_req, j_index, jr_req,
    input  jr_is_ra, jr_target,
    input  exc_req, eret_req, epc,
    output pc, pc4, link_addr, pend_vld,
    output ras_top, ras_empty, ras_miss_cnt
  );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack.
// Push when full overwrites the oldest entry.
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    tptr;

  assign tptr  = ptr - PW'(1);
  assign empty = (cnt == '0);
  assign top   = empty ? '0 : mem[tptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + PW'(1);
      if (cnt != CW'(RAS_DEPTH))
        cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      ptr <= tptr;
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with redirect select, stall-held
// pending redirect, RAS and jr-$ra miss counter.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int          RAS_DEPTH = 4,
  parameter int          CNT_W     = 16
) (
  input logic    clk,
  input logic    reset_n,
  pc_gen_if.slave bus
);
  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VEC);

  redir_e           sel;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pend_pc;
  logic             pend_q;
  logic [CNT_W-1:0] miss_q;
  logic [WIDTH-1:0] boff;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] top;
  logic             empty;

  always_comb begin
    sel = REDIR_NONE;
    if (bus.exc_req)       sel = REDIR_EXC;
    else if (bus.eret_req) sel = REDIR_ERET;
    else if (bus.jr_req)   sel = REDIR_JR;
    else if (bus.jal_req)  sel = REDIR_JAL;
    else if (bus.br_req)   sel = REDIR_BR;
  end

  assign boff = {{(WIDTH-18){bus.br_off[15]}},
                 bus.br_off, 2'b00};

  always_comb begin
    tgt = '0;
    unique case (sel)
      REDIR_EXC:  tgt = EXC_PC;
      REDIR_ERET: tgt = bus.epc;
      REDIR_JR:   tgt = bus.jr_target;
      REDIR_JAL:  tgt = {bus.br_pc[WIDTH-1:28],
                         bus.j_index, 2'b00};
      REDIR_BR:   tgt = bus.link_addr + boff;
      default:    tgt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q    <= RST_PC;
      pend_q  <= 1'b0;
      pend_pc <= '0;
    end else if (sel == REDIR_EXC) begin
      pc_q   <= EXC_PC;
      pend_q <= 1'b0;
    end else if (sel != REDIR_NONE) begin
      if (!bus.stall) begin
        pc_q   <= tgt;
        pend_q <= 1'b0;
      end else begin
        pend_pc <= tgt;
        pend_q  <= 1'b1;
      end
    end else if (!bus.stall) begin
      if (pend_q) begin
        pc_q   <= pend_pc;
        pend_q <= 1'b0;
      end else begin
        pc_q <= pc_q + WIDTH'(4);
      end
    end
  end

  // RAS follows the request pulse even while stalled
  assign push = (sel == REDIR_JAL);
  assign pop  = (sel == REDIR_JR) && bus.jr_is_ra;

  always_ff @(posedge clk) begin
    if (!reset_n)
      miss_q <= '0;
    else if (pop && (empty || top != bus.jr_target)
             && miss_q != '1)
      miss_q <= miss_q + CNT_W'(1);
  end

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (bus.link_addr),
    .top       (top),
    .empty     (empty)
  );

  assign bus.pc           = pc_q;
  assign bus.pc4          = pc_q + WIDTH'(4);
  assign bus.link_addr    = bus.br_pc + WIDTH'(4);
  assign bus.pend_vld     = pend_q;
  assign bus.ras_top      = top;
  assign bus.ras_empty    = empty;
  assign bus.ras_miss_cnt = miss_q;
endmodule
